window_gen_3x3: RTL and testbench

- Streaming producer that feeds the 3x3 convolution engine.
- Accepts a raster-order pixel stream (one signed 8-bit pixel per valid cycle). Buffers two full image rows and emits every fully-populated 3x3 window as nine parallel pixels plus a valid strobe.
- Uses "valid" convolution: no padding.
- Sits between the input feature-map source and the conv_3x3 data_in0..8 inputs.

---
 rtl/window_gen_3x3_pkg.sv | 21 ++
 rtl/window_gen_3x3_if.sv | 30 +++
 rtl/window_gen_3x3_line_buffer.sv | 42 ++++
 rtl/window_gen_3x3.sv | 137 +++++++++++++
 tb/tb_window_gen_3x3.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/window_gen_3x3_pkg.sv
// Shared definitions for the 3x3 window generator: default pixel width and the
// row-major window tap order used by the conv engine's data_in/weight ports.
package window_gen_3x3_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int WIN_TAPS       = 9;

  // Tap index = row*3 + col, top-left first, bottom-right last
  typedef enum logic [3:0] {
    WIN_TL = 4'd0,
    WIN_TC = 4'd1,
    WIN_TR = 4'd2,
    WIN_ML = 4'd3,
    WIN_MC = 4'd4,
    WIN_MR = 4'd5,
    WIN_BL = 4'd6,
    WIN_BC = 4'd7,
    WIN_BR = 4'd8
  } win_idx_e;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle between the feature-map source, the window
// generator and the conv engine. The source side is master, the generator is slave.
interface window_gen_3x3_if
  import window_gen_3x3_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic                     clear;
  logic                     pix_valid;
  logic signed [DATA_W-1:0] pix_in;
  logic signed [DATA_W-1:0] win0, win1, win2;
  logic signed [DATA_W-1:0] win3, win4, win5;
  logic signed [DATA_W-1:0] win6, win7, win8;
  logic                     win_valid;
  logic                     frame_done;

  modport master (
    output clear, pix_valid, pix_in,
    input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
    input  win_valid, frame_done
  );

  modport slave (
    input  clear, pix_valid, pix_in,
    output win0, win1, win2, win3, win4, win5, win6, win7, win8,
    output win_valid, frame_done
  );

endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// Enable-gated delay of DEPTH accepted samples, built as a circular RAM with a
// single pointer: the slot about to be overwritten holds the sample from DEPTH accepts ago.
module window_gen_3x3_line_buffer
  import window_gen_3x3_pkg::*;
#(
  parameter int DEPTH  = 28,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         ptr;

  assign dout = mem[ptr];

  // Storage is deliberately unreset; stale contents are masked by the emission rule
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-order pixel stream to 3x3 sliding windows ("valid" convolution, no padding).
// Two cascaded line buffers supply the upper rows; a window is emitted once row>=2 and col>=2.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  window_gen_3x3_if.slave  bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             emit;

  logic signed [DATA_W-1:0] lb0_out;
  logic signed [DATA_W-1:0] lb1_out;

  logic signed [DATA_W-1:0] top_q [2];
  logic signed [DATA_W-1:0] mid_q [2];
  logic signed [DATA_W-1:0] bot_q [2];

  logic signed [DATA_W-1:0] win_nxt [WIN_TAPS];
  logic signed [DATA_W-1:0] win_q   [WIN_TAPS];
  logic                     win_valid_q;
  logic                     frame_done_q;

  assign accept   = bus.pix_valid && !bus.clear;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign emit     = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  window_gen_3x3_line_buffer #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W)
  ) u_lb0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .din   (bus.pix_in),
    .dout  (lb0_out)
  );

  window_gen_3x3_line_buffer #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W)
  ) u_lb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .din   (lb0_out),
    .dout  (lb1_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // The incoming right column is {lb1_out, lb0_out, pix_in}; the left two come from the shifters
  always_comb begin
    win_nxt[WIN_TL] = top_q[0];
    win_nxt[WIN_TC] = top_q[1];
    win_nxt[WIN_TR] = lb1_out;
    win_nxt[WIN_ML] = mid_q[0];
    win_nxt[WIN_MC] = mid_q[1];
    win_nxt[WIN_MR] = lb0_out;
    win_nxt[WIN_BL] = bot_q[0];
    win_nxt[WIN_BC] = bot_q[1];
    win_nxt[WIN_BR] = bus.pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_q[i] <= '0;
      end
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= emit;
      frame_done_q <= emit && row_last && col_last;
      if (accept) begin
        top_q[0] <= top_q[1];
        top_q[1] <= lb1_out;
        mid_q[0] <= mid_q[1];
        mid_q[1] <= lb0_out;
        bot_q[0] <= bot_q[1];
        bot_q[1] <= bus.pix_in;
      end
      if (emit) begin
        for (int i = 0; i < WIN_TAPS; i++) begin
          win_q[i] <= win_nxt[i];
        end
      end
    end
  end

  assign bus.win0       = win_q[WIN_TL];
  assign bus.win1       = win_q[WIN_TC];
  assign bus.win2       = win_q[WIN_TR];
  assign bus.win3       = win_q[WIN_ML];
  assign bus.win4       = win_q[WIN_MC];
  assign bus.win5       = win_q[WIN_MR];
  assign bus.win6       = win_q[WIN_BL];
  assign bus.win7       = win_q[WIN_BC];
  assign bus.win8       = win_q[WIN_BR];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a 4x4 image: a full-frame reference image
// produces expected windows at drive time; a negedge monitor pops and compares them.
module tb_window_gen_3x3;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int DATA_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  window_gen_3x3_if #(.DATA_W(DATA_W)) bus ();

  window_gen_3x3 #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DATA_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [72:0] exp_q [$];
  logic [71:0] got_q [$];
  logic [71:0] last_win = '0;
  logic [71:0] cur_win;
  logic [72:0] mon_e;
  bit          expect_valid = 1'b0;
  int          m_col = 0;
  int          m_row = 0;
  int          fd_count = 0;
  logic signed [7:0] img [IMG_H][IMG_W];

  assign cur_win = {bus.win0, bus.win1, bus.win2, bus.win3, bus.win4,
                    bus.win5, bus.win6, bus.win7, bus.win8};

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [71:0] pack_win(input int p [9]);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      r[(8-i)*8 +: 8] = p[i][7:0];
    end
    return r;
  endfunction

  // Drive one cycle of inputs; the reference image decides what the DUT owes next cycle
  task automatic applyStimulus(input bit v, input logic [7:0] p, input bit clr);
    logic [71:0] w;
    bus.pix_valid = v;
    bus.pix_in    = p;
    bus.clear     = clr;
    @(posedge clk);
    expect_valid = 1'b0;
    if (clr) begin
      m_col = 0;
      m_row = 0;
    end else if (v) begin
      img[m_row][m_col] = p;
      if (m_row >= 2 && m_col >= 2) begin
        w = '0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            w[(8-(r*3+c))*8 +: 8] = img[m_row-2+r][m_col-2+c];
          end
        end
        exp_q.push_back({1'(m_row == IMG_H-1 && m_col == IMG_W-1), w});
        expect_valid = 1'b1;
      end
      if (m_col == IMG_W-1) begin
        m_col = 0;
        m_row = (m_row == IMG_H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("win_valid", 72'(bus.win_valid), 72'(expect_valid));
      if (bus.win_valid) begin
        checkOutput("sb_pending", 72'(exp_q.size() != 0), 72'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("window", cur_win, mon_e[71:0]);
          checkOutput("frame_done", 72'(bus.frame_done), 72'(mon_e[72]));
        end
        got_q.push_back(cur_win);
        last_win = cur_win;
        if (bus.frame_done) fd_count++;
      end else begin
        checkOutput("hold", cur_win, last_win);
        checkOutput("frame_done_idle", 72'(bus.frame_done), 72'(0));
      end
    end
  end

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    bus.pix_valid = 1'b0;
    bus.clear     = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_win", cur_win, 72'(0));
    checkOutput("rst_win_valid", 72'(bus.win_valid), 72'(0));
    checkOutput("rst_frame_done", 72'(bus.frame_done), 72'(0));
    m_col        = 0;
    m_row        = 0;
    expect_valid = 1'b0;
    last_win     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic begin_test();
    got_q.delete();
    fd_count = 0;
  endtask

  task automatic end_test(input int n_win, input int n_fd);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("sb_drained", 72'(exp_q.size()), 72'(0));
    checkOutput("win_count", 72'(got_q.size()), 72'(n_win));
    checkOutput("fd_count", 72'(fd_count), 72'(n_fd));
  endtask

  task automatic stream_frame(input int base, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'($urandom), 1'b0);
      end
      applyStimulus(1'b1, 8'(base + k), 1'b0);
    end
  endtask

  int ref_first [9];
  int ref_last  [9];
  int ref_f2    [9];
  int ref_clr   [9];

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.clear     = 1'b0;
    ref_first = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    ref_last  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    ref_f2    = '{16, 17, 18, 20, 21, 22, 24, 25, 26};
    ref_clr   = '{100, 101, 102, 104, 105, 106, 108, 109, 110};

    pulse_reset();

    $display("[TB] back-to-back frame");
    begin_test();
    stream_frame(0, 16, 1'b0);
    end_test(4, 1);
    checkOutput("first_win", got_q[0], pack_win(ref_first));
    checkOutput("last_win", got_q[3], pack_win(ref_last));

    $display("[TB] frame with random gaps");
    begin_test();
    stream_frame(0, 16, 1'b1);
    end_test(4, 1);
    checkOutput("gap_first_win", got_q[0], pack_win(ref_first));
    checkOutput("gap_last_win", got_q[3], pack_win(ref_last));

    $display("[TB] two frames back-to-back");
    begin_test();
    stream_frame(0, 16, 1'b0);
    stream_frame(16, 16, 1'b0);
    end_test(8, 2);
    checkOutput("frame2_first_win", got_q[4], pack_win(ref_f2));

    $display("[TB] signed extremes");
    begin_test();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, (k % 2 == 0) ? 8'h80 : 8'h7F, 1'b0);
    end
    end_test(4, 1);
    checkOutput("signed_win0", 72'(got_q[0][71:64]), 72'(8'h80));
    checkOutput("signed_win1", 72'(got_q[0][63:56]), 72'(8'h7F));

    $display("[TB] clear mid-frame");
    begin_test();
    stream_frame(0, 9, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b1);
    stream_frame(100, 16, 1'b0);
    end_test(4, 1);
    checkOutput("clear_first_win", got_q[0], pack_win(ref_clr));

    $display("[TB] async reset mid-frame");
    begin_test();
    stream_frame(0, 11, 1'b0);
    pulse_reset();
    begin_test();
    stream_frame(0, 16, 1'b0);
    end_test(4, 1);
    checkOutput("rst_first_win", got_q[0], pack_win(ref_first));
    checkOutput("rst_last_win", got_q[3], pack_win(ref_last));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
